// File: rtl/fir_run_controller.sv
// Run controller: conditions pwr/dbg/stp buttons into a registered cpu_en and stops on a PC match.
// Latency 3+DBNC_CYCLES edges from button to cpu_en; no backpressure, every accepted press event acts.
module fir_run_controller #(
    parameter int N           = 24,
    parameter int DBNC_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr,
    input  logic             dbg,
    input  logic             stp,
    input  logic [N-1:0]     pc_address,
    input  logic [N-1:0]     halt_address,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [15:0]      step_count
);
    localparam int              DB_W    = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DBNC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_DONE = 2'b11
    } run_state_t;

    // Bit 0 = pwr, bit 1 = dbg, bit 2 = stp throughout.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      db_level;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    run_state_t st;
    run_state_t st_next;
    logic       step_fire;
    logic       halt_match;

    assign btn_raw = {stp, dbg, pwr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // A sample equal to the accepted level restarts the run of differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level <= '1;
            press    <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                    press[i]    <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign halt_match = cpu_en && (pc_address == halt_address);

    always_comb begin
        st_next   = st;
        step_fire = 1'b0;
        unique case (st)
            ST_OFF: begin
                if (press[0]) begin
                    st_next = db_level[1] ? ST_RUN : ST_HALT;
                end
            end
            ST_RUN: begin
                if (halt_match) begin
                    st_next = ST_DONE;
                end else if (press[1]) begin
                    st_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_match) begin
                    st_next = ST_DONE;
                end else if (press[1]) begin
                    st_next = ST_RUN;
                end else if (press[2]) begin
                    step_fire = 1'b1;
                end
            end
            ST_DONE: begin
                if (press[0]) begin
                    st_next = ST_OFF;
                end
            end
            default: st_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= ST_OFF;
            cpu_en      <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            step_count  <= '0;
        end else begin
            st     <= st_next;
            cpu_en <= (st_next == ST_RUN) || step_fire;
            done   <= (st_next == ST_DONE);
            if (cpu_en && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (step_fire && (step_count != 16'hFFFF)) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

    assign state = st;

endmodule

// File: doc/fir_run_controller.md
Name: fir_run_controller

Overview:
- Execution controller for the FIR ASIP. Converts the raw power, debug and step push-buttons into a clean processor clock-enable.
- Supports free-run, halt and single-step, and stops the core when the PC reaches a programmable halt address.
- Sits between board buttons and processor/memory clock gating. Exports status and cycle/step counters for display and debug.

Parameters:
- N, 24, width of PC address
- DBNC_CYCLES, 4, consecutive synchronized samples a button must hold before its level is accepted (min 1)
- CNT_W, 32, width of cycle_count

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- pwr  in  1  power/start button, raw, active-low
- dbg  in  1  debug button, raw, active-low
- stp  in  1  step button, raw, active-low
- pc_address  in  N  current processor PC
- halt_address  in  N  PC value that terminates execution (quasi-static)
- cpu_en  out  1  registered clock-enable for processor and memory
- state  out  2  00 OFF, 01 RUN, 10 HALT, 11 DONE
- done  out  1  high while state == DONE
- cycle_count  out  CNT_W  cycles with cpu_en == 1
- step_count  out  16  single steps issued

Behaviour:
- Reset (rst low, async): state OFF, cpu_en 0, done 0, counters 0, synchronizers and debouncers at released level (1). Reset mid-run drops cpu_en immediately.
- Button conditioning, identical for pwr, dbg and stp:
  - 2-FF synchronizer feeds a debouncer.
  - Debounced level changes only after DBNC_CYCLES consecutive equal synchronized samples. Any differing sample restarts the count.
  - Press event = one-cycle pulse on a debounced 1->0 transition. Release produces no event.
- Latency: from the first clk edge sampling the raw button low, cpu_en/state update on edge 3+DBNC_CYCLES.
- cpu_en is registered: cpu_en_next = (state_next == RUN) | step_fire.
- FSM:
  - OFF: cpu_en 0. pwr event -> RUN if debounced dbg is released, else HALT. dbg and stp events are ignored.
  - RUN: cpu_en 1.
    - Halt match (cpu_en == 1 and pc_address == halt_address) -> DONE.
    - Otherwise dbg event -> HALT.
    - pwr and stp events are ignored.
  - HALT: cpu_en 0.
    - dbg event -> RUN.
    - Otherwise stp event -> step_fire: cpu_en high for exactly one cycle, step_count +1, state stays HALT.
    - If a halt match occurs during the step cycle -> DONE.
  - DONE: cpu_en 0, done 1. pwr event -> OFF; counters are held, not cleared. All other events are ignored.
- Priority on simultaneous events: halt match > dbg > stp > pwr.
- A stp event in HALT arriving during an already-active step cycle is accepted and produces a second single-cycle pulse next cycle; no pulse is merged or lost.
- cycle_count increments on every edge where cpu_en == 1 and saturates at all-ones. step_count saturates at 16'hFFFF.
- halt_address is sampled combinationally each cycle; changing it while RUN takes effect on the next compare.

Test Plan:
- Reset check: rst low, buttons released -> state 00, cpu_en 0, done 0, cycle_count 0, step_count 0. Pull rst low mid-RUN -> cpu_en 0 asynchronously.
- Start and finish:
  - Stimulus: DBNC_CYCLES=4, halt_address 24'h000010; bench PC increments by 1 per cpu_en cycle from 0; hold pwr low 10 cycles.
  - Response: cpu_en rises on edge 7 after the first low sample; state 01; at PC 24'h000010 state goes 11 and cpu_en 0 on the next edge; cycle_count = 17.
- Glitch reject: pwr low for 3 synchronized cycles then high -> no event, state stays 00, cpu_en 0.
- Debug and step:
  - RUN, then dbg press -> state 10, cpu_en 0.
  - Three separate stp presses -> exactly three single-cycle cpu_en pulses; step_count = 3; PC advances by 3.
  - Then dbg press -> state 01.
- Simultaneous events: in HALT, dbg and stp press events on the same cycle -> state 01, step_count unchanged. In RUN, dbg event on the halt-match cycle -> state 11.
- Start in debug: hold dbg low, then press pwr -> state 10 directly, cpu_en never asserted until stp or dbg release-and-press.
